// File: rtl/subbytes_seq_pkg.sv
// rtl/subbytes_seq_pkg.sv - AES byte/state types, FSM encoding and GF(2^8) helpers
package subbytes_seq_pkg;

    typedef logic [7:0] aes_byte_t;

    // st[row][col] lands on bits [8*(row*4+col) +: 8] of the flat vector
    typedef aes_byte_t [3:0][3:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    function automatic aes_state_t vec_to_state(input logic [127:0] v);
        return aes_state_t'(v);
    endfunction

    function automatic logic [127:0] state_to_vec(input aes_state_t s);
        return 128'(s);
    endfunction

    // Carry-less multiply reduced by the AES polynomial x^8+x^4+x^3+x+1
    function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t p;
        aes_byte_t aa;
        aes_byte_t bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0
    function automatic aes_byte_t gf_inv(input aes_byte_t a);
        aes_byte_t sq;
        aes_byte_t acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 2; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

endpackage

// File: rtl/subbytes_seq_sbox.sv
// rtl/subbytes_seq_sbox.sv - combinational AES forward sbox (inverse + affine)
module sbox
    import subbytes_seq_pkg::*;
(
    input  logic [7:0] lhs,
    output logic [7:0] o
);

    aes_byte_t inv;

    // Field inverse followed by the affine transform b ^ rotl1..rotl4(b) ^ 0x63
    always_comb begin
        inv = gf_inv(lhs);
        o   = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
    end

endmodule

// File: rtl/subbytes_seq.sv
// rtl/subbytes_seq.sv - time-multiplexed SubBytes using LANES shared sboxes
module subbytes_seq
    import subbytes_seq_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_state,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int STEPS = 16 / LANES;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    fsm_state_t       state_q;
    fsm_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_last;
    aes_state_t       src_q;
    logic [127:0]     src_vec;
    logic [127:0]     out_q;
    int               byte_base;
    logic [7:0]       lane_in  [LANES];
    logic [7:0]       lane_out [LANES];

    assign cnt_last  = (cnt_q == CNT_W'(STEPS - 1));
    assign src_vec   = state_to_vec(src_q);
    assign out_state = out_q;

    // First byte handled this cycle; with one step the counter never moves
    always_comb begin
        byte_base = 0;
        if (STEPS > 1) begin
            byte_base = int'(cnt_q) * LANES;
        end
    end

    // Lane mux: lane j reads source byte byte_base+j
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_in[j] = src_vec[(byte_base + j) * 8 +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox u_sbox (
            .lhs (lane_in[g]),
            .o   (lane_out[g])
        );
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (cnt_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Source capture, step counter and lane demux into the result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            src_q <= '0;
            out_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        src_q <= vec_to_state(in_state);
                        cnt_q <= '0;
                    end
                end
                ST_BUSY: begin
                    for (int j = 0; j < LANES; j++) begin
                        out_q[(byte_base + j) * 8 +: 8] <= lane_out[j];
                    end
                    cnt_q <= cnt_last ? '0 : cnt_q + CNT_W'(1);
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

endmodule

// File: doc/subbytes_seq.md
Name: subbytes_seq

Overview:
- Time-multiplexed SubBytes engine: LANES shared sbox instances process a 4x4 AES state in 16/LANES cycles.
- Replaces the fully parallel 16-sbox SubBytes where area matters.
- Sits between the round-key/state register and shiftRows in an iterative Cipher.
- valid/ready handshake on input and on output.

Parameters:
- LANES, 4, number of shared sbox instances; legal values 1, 2, 4, 8, 16.
- STEPS, 16/LANES, derived, not overridable; cycles per state.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_state  in  128  input state; byte i = row*4+col occupies bits [8i+7:8i].
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept a state.
- out_state  out  128  substituted state; same byte mapping as in_state.
- out_valid  out  1  out_state valid.
- out_ready  in  1  downstream accepts out_state.
- busy  out  1  high while in BUSY.

Behaviour:
- Reset values:
  - FSM=IDLE, step counter=0.
  - in_ready=1, out_valid=0, busy=0.
  - out_state=0, input capture register=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_state into src register, clear counter, go to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle, lanes j=0..LANES-1 feed src byte (cnt*LANES+j) to sbox j. The sbox outputs are registered into out_state byte (cnt*LANES+j).
    - Counter increments each BUSY cycle.
    - At cnt==STEPS-1: counter wraps to 0 and FSM goes to DONE.
  - DONE: out_valid=1, out_state stable. On out_ready, go to IDLE and drop out_valid.
- Latency: out_valid rises exactly STEPS cycles after the accepting edge (4 for LANES=4, 16 for LANES=1, 1 for LANES=16).
- Throughput: one state per STEPS+2 cycles minimum. There is no back-to-back accept in DONE; in_ready stays 0 until the FSM returns to IDLE.
- Holding rules:
  - in_valid while not in IDLE is ignored; the source must hold.
  - in_state changes after acceptance do not affect the result (src is captured).
- Output stability:
  - out_state is only updated in BUSY.
  - Bytes not yet processed keep their previous-state values. Downstream must sample only when out_valid=1.
- out_ready while not in DONE has no effect.
- rst asserted in any state, mid-BUSY included:
  - Next cycle is IDLE with reset values.
  - The partial result is discarded; no spurious out_valid.
- Counter width: clog2(STEPS), minimum 1 bit. For LANES=16 the counter is unused, and BUSY lasts exactly one cycle.

Decomposition:
- Shared package Cipher_defs:
  - AES byte and state typedefs (8-bit byte, 4x4 array of bytes).
  - State/vector conversion helpers.
  - FSM state encoding (IDLE, BUSY, DONE).
- Sub-module: existing combinational sbox (8-bit lhs in, 8-bit o out), instantiated LANES times.
- Lane-to-byte mux and demux stay in subbytes_seq.

Test Plan:
- Basic, LANES=4: in_state all 0x00, in_valid=1, out_ready=1.
  - Expected: accepted in IDLE, busy high for 4 cycles, out_valid 4 cycles after accept, out_state all 0x63, then IDLE.
- FIPS-197 round-1 vector: byte0=0x19, byte1=0x3d, byte2=0xe3, byte3=0xbe, rest 0x00.
  - Expected: bytes 0..3 = 0xd4, 0x27, 0x11, 0xae; rest 0x63.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - Expected: out_valid and out_state held constant, in_ready=0 throughout.
  - Raising out_ready gives IDLE next cycle, with in_ready=1.
- Input during BUSY: second in_valid with in_state all 0xff while busy.
  - Expected: ignored, first result unchanged.
  - After return to IDLE that state is accepted and yields all 0x16.
- Mid-op reset: assert rst on the 2nd BUSY cycle.
  - Expected: next cycle in_ready=1, busy=0, out_valid=0, out_state=0.
  - A subsequent all-0x01 state yields all 0x7c.
- Parameter sweep LANES=1/2/8/16 with random states vs. a reference sbox table.
  - Expected: latency 16/8/2/1 cycles, bit-exact outputs.
